// File: rtl/nf_dm_router_pkg.sv
// Shared types and constants for the data-memory router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, error read-data pattern, default slave address map.
package nf_dm_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } nf_dmr_st_t;

    // Returned as read data on unmapped or timed-out accesses.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Default address map: 4 KiB windows.
    localparam logic [31:0] MAP_RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] MAP_RAM_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] MAP_GPIO_BASE  = 32'h0001_0000;
    localparam logic [31:0] MAP_GPIO_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] MAP_UART_BASE  = 32'h0002_0000;
    localparam logic [31:0] MAP_UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] MAP_SPARE_BASE = 32'h0003_0000;
    localparam logic [31:0] MAP_SPARE_MASK = 32'hFFFF_F000;

endpackage

// File: rtl/nf_dm_router_if.sv
// Bundle of the CPU data port and the broadcast slave bus seen by the router.
// Latency: n/a (wires only).
// Backpressure: CPU holds req_dm until req_ack_dm; slaves stall by withholding req_ack_s.
//
// Modports: master = CPU plus slave environment (drives requests and slave responses),
//           slave  = the router itself.
interface nf_dm_router_if #(
    parameter int SLV_N = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) ();
    logic [AW-1:0]       addr_dm;
    logic                we_dm;
    logic [DW-1:0]       wd_dm;
    logic                req_dm;
    logic [DW-1:0]       rd_dm;
    logic                req_ack_dm;
    logic                err_dm;
    logic [AW-1:0]       addr_s;
    logic [DW-1:0]       wd_s;
    logic [SLV_N-1:0]    we_s;
    logic [SLV_N-1:0]    req_s;
    logic [SLV_N*DW-1:0] rd_s;
    logic [SLV_N-1:0]    req_ack_s;

    modport master (
        output addr_dm, we_dm, wd_dm, req_dm, rd_s, req_ack_s,
        input  rd_dm, req_ack_dm, err_dm, addr_s, wd_s, we_s, req_s
    );

    modport slave (
        input  addr_dm, we_dm, wd_dm, req_dm, rd_s, req_ack_s,
        output rd_dm, req_ack_dm, err_dm, addr_s, wd_s, we_s, req_s
    );
endinterface

// File: rtl/nf_dm_router_dec.sv
// Combinational address decoder: one-hot hit vector, lowest index wins, zero on miss.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: addr_i (address to decode), hit_o (one-hot or all-zero hit vector).
module nf_addr_dec #(
    parameter int              N    = 4,
    parameter int              AW   = 32,
    parameter logic [N*AW-1:0] BASE = '0,
    parameter logic [N*AW-1:0] MASK = '0
) (
    input  logic [AW-1:0] addr_i,
    output logic [N-1:0]  hit_o
);
    logic [N-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int k = 0; k < N; k++) begin
            raw_hit[k] = ((addr_i & MASK[k*AW +: AW]) == BASE[k*AW +: AW]);
        end
    end

    // Two's-complement trick isolates the lowest set bit, giving index priority on overlap.
    assign hit_o = raw_hit & (~raw_hit + N'(1));

endmodule

// File: rtl/nf_dm_router.sv
// Data-memory router: decodes CPU address, forwards one transaction to a slave, returns data.
// Latency: zero-wait slave -> req_s one cycle after req_dm sampled, req_ack_dm one cycle later.
// Backpressure: slave stalls via req_ack_s up to TO_CYC cycles, then the CPU gets an error ack.
//
// Ports: clk, resetn (synchronous, active-high), bus (nf_dm_router_if.slave: CPU port in,
//        read data/ack/err out; latched addr/wdata and one-hot req/we to slaves, slave rd/ack in).
module nf_dm_router
    import nf_dm_router_pkg::*;
#(
    parameter int                  SLV_N    = 4,
    parameter int                  AW       = 32,
    parameter int                  DW       = 32,
    parameter logic [SLV_N*AW-1:0] SLV_BASE = {MAP_SPARE_BASE, MAP_UART_BASE,
                                               MAP_GPIO_BASE,  MAP_RAM_BASE},
    parameter logic [SLV_N*AW-1:0] SLV_MASK = {MAP_SPARE_MASK, MAP_UART_MASK,
                                               MAP_GPIO_MASK,  MAP_RAM_MASK},
    parameter int                  TO_CYC   = 255
) (
    input  logic            clk,
    input  logic            resetn,
    nf_dm_router_if.slave   bus
);
    localparam int TW = $clog2(TO_CYC + 1);

    nf_dmr_st_t       st_q,   st_d;
    logic [SLV_N-1:0] req_q,  req_d;
    logic [SLV_N-1:0] we_q,   we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wd_q,   wd_d;
    logic [DW-1:0]    rd_q,   rd_d;
    logic             err_q,  err_d;
    logic             ack_q,  ack_d;
    logic [TW-1:0]    tmr_q,  tmr_d;

    logic [SLV_N-1:0] hit;
    logic             sel_ack;
    logic             tmr_exp;
    logic [DW-1:0]    rd_sel;

    nf_addr_dec #(
        .N    (SLV_N),
        .AW   (AW),
        .BASE (SLV_BASE),
        .MASK (SLV_MASK)
    ) u_dec (
        .addr_i (bus.addr_dm),
        .hit_o  (hit)
    );

    // req_q is the one-hot selection while BUSY, so it masks both ack and read data.
    assign sel_ack = |(bus.req_ack_s & req_q);
    assign tmr_exp = (tmr_q == TW'(TO_CYC - 1));

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < SLV_N; k++) begin
            if (req_q[k]) begin
                rd_sel = bus.rd_s[k*DW +: DW];
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        req_d  = req_q;
        we_d   = we_q;
        addr_d = addr_q;
        wd_d   = wd_q;
        rd_d   = rd_q;
        err_d  = err_q;
        ack_d  = 1'b0;
        tmr_d  = tmr_q;
        case (st_q)
            IDLE: begin
                if (bus.req_dm) begin
                    if (|hit) begin
                        req_d  = hit;
                        we_d   = hit & {SLV_N{bus.we_dm}};
                        addr_d = bus.addr_dm;
                        wd_d   = bus.wd_dm;
                        tmr_d  = '0;
                        st_d   = BUSY;
                    end else begin
                        err_d = 1'b1;
                        rd_d  = DW'(ERR_DATA);
                        ack_d = 1'b1;
                        st_d  = RESP;
                    end
                end
            end
            BUSY: begin
                // Ack is checked first so an ack on the expiry cycle completes normally.
                if (sel_ack) begin
                    if (!(|we_q)) begin
                        rd_d = rd_sel;
                    end
                    err_d = 1'b0;
                    req_d = '0;
                    we_d  = '0;
                    ack_d = 1'b1;
                    st_d  = RESP;
                end else if (tmr_exp) begin
                    err_d = 1'b1;
                    rd_d  = DW'(ERR_DATA);
                    req_d = '0;
                    we_d  = '0;
                    ack_d = 1'b1;
                    st_d  = RESP;
                end else begin
                    // Never passes TO_CYC-1, so the counter cannot wrap.
                    tmr_d = tmr_q + TW'(1);
                end
            end
            RESP: begin
                st_d = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            st_q   <= IDLE;
            req_q  <= '0;
            we_q   <= '0;
            addr_q <= '0;
            wd_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            ack_q  <= 1'b0;
            tmr_q  <= '0;
        end else begin
            st_q   <= st_d;
            req_q  <= req_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            wd_q   <= wd_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
            ack_q  <= ack_d;
            tmr_q  <= tmr_d;
        end
    end

    assign bus.req_s      = req_q;
    assign bus.we_s       = we_q;
    assign bus.addr_s     = addr_q;
    assign bus.wd_s       = wd_q;
    assign bus.rd_dm      = rd_q;
    assign bus.err_dm     = err_q;
    assign bus.req_ack_dm = ack_q;

endmodule

// File: tb/tb_nf_dm_router.sv
// Bench for nf_dm_router: directed scenarios plus randomized traffic against a timeline model.
// Latency: n/a.
// Backpressure: slave models stall for a chosen number of cycles or never answer.
module tb_nf_dm_router;
    import nf_dm_router_pkg::*;

    localparam int SLV_N = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TO    = 4;
    localparam int NC    = 8192;
    localparam int NEVER = 1000;

    // Slot 3 overlaps the RAM window so priority is exercised.
    localparam logic [SLV_N*AW-1:0] BASE = {32'h0000_0000, MAP_UART_BASE, MAP_GPIO_BASE, MAP_RAM_BASE};
    localparam logic [SLV_N*AW-1:0] MASK = {32'hFFFF_0000, MAP_UART_MASK, MAP_GPIO_MASK, MAP_RAM_MASK};

    // Model's own copy of the map.
    logic [31:0] m_base [4] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_0000};
    logic [31:0] m_mask [4] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    nf_dm_router_if #(.SLV_N(SLV_N), .AW(AW), .DW(DW)) bus ();

    nf_dm_router #(
        .SLV_N(SLV_N), .AW(AW), .DW(DW),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TO_CYC(TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_ack = -10;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    // Timeline model: expected value after posedge number n, indexed by n.
    bit [3:0]  ex_req   [NC];
    bit [3:0]  ex_we    [NC];
    bit        ev_ack   [NC];
    bit        ev_err   [NC];
    bit        ev_rdupd [NC];
    bit [31:0] ev_rd    [NC];
    bit        ev_lat   [NC];
    bit [31:0] ev_addr  [NC];
    bit [31:0] ev_wd    [NC];
    bit        ev_rst   [NC];

    int          slv_wait [4] = '{0, 0, 0, 0};
    logic [31:0] slv_data [4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            if ((a & m_mask[k]) == m_base[k]) return k;
        end
        return -1;
    endfunction

    // Per-cycle compare against held model state.
    bit [31:0] m_rd = 0, m_addr = 0, m_wd = 0;
    bit        m_err = 0;
    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            if (ev_rst[cyc]) begin
                m_rd = 0; m_err = 0; m_addr = 0; m_wd = 0;
            end
            if (ev_lat[cyc]) begin
                m_addr = ev_addr[cyc];
                m_wd   = ev_wd[cyc];
            end
            if (ev_ack[cyc]) begin
                m_err = ev_err[cyc];
                if (ev_rdupd[cyc]) m_rd = ev_rd[cyc];
            end
            chk("req_s",      32'(bus.req_s),      32'(ex_req[cyc]));
            chk("we_s",       32'(bus.we_s),       32'(ex_we[cyc]));
            chk("req_ack_dm", 32'(bus.req_ack_dm), 32'(ev_ack[cyc]));
            chk("err_dm",     32'(bus.err_dm),     32'(m_err));
            chk("rd_dm",      bus.rd_dm,           m_rd);
            chk("addr_s",     bus.addr_s,          m_addr);
            chk("wd_s",       bus.wd_s,            m_wd);
        end
    end

    // Slave models: slave k acks after slv_wait[k] wait cycles; idle slaves emit noise.
    initial begin
        int          cnt [4];
        logic [3:0]  a_v;
        logic [127:0] r_v;
        cnt = '{0, 0, 0, 0};
        bus.req_ack_s = '0;
        bus.rd_s      = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (bus.req_s[k] === 1'b1) begin
                    cnt[k]++;
                    a_v[k] = (cnt[k] == slv_wait[k] + 1);
                end else begin
                    cnt[k] = 0;
                    a_v[k] = 1'($urandom_range(0, 1));
                end
                r_v[k*32 +: 32] = (a_v[k] && bus.req_s[k] === 1'b1) ? slv_data[k] : $urandom;
            end
            bus.req_ack_s = a_v;
            bus.rd_s      = r_v;
        end
    end

    // Issue one CPU transaction, record the model timeline, wait for the ack.
    task automatic txn(input logic [31:0] a, input bit w, input logic [31:0] d, input int wt,
                       input logic [31:0] sd, output int lat, output logic [31:0] rd,
                       output logic e);
        int  t, s, samp, n;
        bit  got, tout;
        t = decode(a);
        s = cyc;
        samp = (s == last_ack) ? s + 2 : s + 1;   // request is not looked at in the ack cycle
        if (t >= 0) begin
            slv_wait[t] = wt;
            slv_data[t] = sd;
            n    = (wt + 1 < TO) ? wt + 1 : TO;
            tout = (wt + 1 > TO);
            ev_lat[samp]  = 1'b1;
            ev_addr[samp] = a;
            ev_wd[samp]   = d;
            for (int i = 0; i < n; i++) begin
                ex_req[samp+i] = 4'(1 << t);
                if (w) ex_we[samp+i] = 4'(1 << t);
            end
            ev_ack[samp+n]   = 1'b1;
            ev_err[samp+n]   = tout;
            ev_rdupd[samp+n] = tout || !w;
            ev_rd[samp+n]    = tout ? 32'hDEAD_BEEF : sd;
        end else begin
            ev_ack[samp]   = 1'b1;
            ev_err[samp]   = 1'b1;
            ev_rdupd[samp] = 1'b1;
            ev_rd[samp]    = 32'hDEAD_BEEF;
        end
        bus.addr_dm = a;
        bus.we_dm   = w;
        bus.wd_dm   = d;
        bus.req_dm  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.req_ack_dm === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL ack_wait addr=%h got=no_ack want=ack", a);
        end
        lat = cyc - s;
        rd  = bus.rd_dm;
        e   = bus.err_dm;
        last_ack = cyc;
        bus.req_dm = 1'b0;
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          c;
        logic [31:0] a;
        bus.addr_dm = '0;
        bus.we_dm   = 1'b0;
        bus.wd_dm   = '0;
        bus.req_dm  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_s", 32'(bus.req_s), 32'h0);
        chk("rst_we_s",  32'(bus.we_s),  32'h0);
        chk("rst_ack",   32'(bus.req_ack_dm), 32'h0);
        chk("rst_err",   32'(bus.err_dm), 32'h0);
        chk("rst_rd",    bus.rd_dm,  32'h0);
        chk("rst_addr",  bus.addr_s, 32'h0);
        chk("rst_wd",    bus.wd_s,   32'h0);
        resetn = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // RAM read, zero-wait slave.
        txn(32'h0000_0010, 1'b0, 32'h0, 0, 32'h1234_5678, lat, rd, e);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_rd",  rd, 32'h1234_5678);
        chk("t1_err", 32'(e), 32'h0);
        idle(1);

        // GPIO write, three wait cycles; read data must not move.
        txn(32'h0001_0004, 1'b1, 32'h0000_00A5, 3, 32'h7777_7777, lat, rd, e);
        chk("t2_lat", 32'(lat), 32'd5);
        chk("t2_rd",  rd, 32'h1234_5678);
        chk("t2_err", 32'(e), 32'h0);
        idle(1);

        // Unmapped.
        txn(32'hF000_0000, 1'b0, 32'h0, 0, 32'h0, lat, rd, e);
        chk("t3_lat", 32'(lat), 32'd1);
        chk("t3_rd",  rd, 32'hDEAD_BEEF);
        chk("t3_err", 32'(e), 32'h1);
        idle(2);

        // Timeout, then a back-to-back good read clears the error.
        txn(32'h0002_0008, 1'b0, 32'h0, NEVER, 32'h0, lat, rd, e);
        chk("t4_lat", 32'(lat), 32'd5);
        chk("t4_rd",  rd, 32'hDEAD_BEEF);
        chk("t4_err", 32'(e), 32'h1);
        txn(32'h0000_0020, 1'b0, 32'h0, 0, 32'hCAFE_0001, lat, rd, e);
        chk("t4b_lat", 32'(lat), 32'd3);
        chk("t4b_rd",  rd, 32'hCAFE_0001);
        chk("t4b_err", 32'(e), 32'h0);
        idle(1);

        // Ack on the expiry cycle completes normally.
        txn(32'h0001_0000, 1'b0, 32'h0, TO - 1, 32'h5A5A_0005, lat, rd, e);
        chk("t5_lat", 32'(lat), 32'd5);
        chk("t5_rd",  rd, 32'h5A5A_0005);
        chk("t5_err", 32'(e), 32'h0);
        idle(1);

        // Overlap: both slot 0 and slot 3 match, slot 0 must answer.
        slv_wait[3] = 0;
        slv_data[3] = 32'h0000_BBBB;
        txn(32'h0000_0040, 1'b0, 32'h0, 0, 32'h0000_AAAA, lat, rd, e);
        chk("t6_ovl_rd", rd, 32'h0000_AAAA);
        idle(1);
        txn(32'h0000_8000, 1'b0, 32'h0, 1, 32'h0000_3333, lat, rd, e);
        chk("t6_s3_rd",  rd, 32'h0000_3333);
        chk("t6_s3_lat", 32'(lat), 32'd3);
        idle(1);

        // Reset while BUSY with a slave that never answers.
        slv_wait[1] = NEVER;
        c = cyc;
        for (int i = 0; i < TO; i++) ex_req[c+1+i] = 4'b0010;
        ev_lat[c+1]  = 1'b1;
        ev_addr[c+1] = 32'h0001_0100;
        ev_wd[c+1]   = 32'h0000_1111;
        bus.addr_dm = 32'h0001_0100;
        bus.we_dm   = 1'b0;
        bus.wd_dm   = 32'h0000_1111;
        bus.req_dm  = 1'b1;
        idle(2);
        chk("t6_busy_req", 32'(bus.req_s), 32'h2);
        resetn     = 1'b1;
        bus.req_dm = 1'b0;
        for (int i = cyc + 1; i < cyc + 12; i++) begin
            ex_req[i] = '0; ex_we[i] = '0; ev_ack[i] = 1'b0; ev_lat[i] = 1'b0;
        end
        ev_rst[cyc+1] = 1'b1;
        idle(1);
        chk("t6_rst_req", 32'(bus.req_s), 32'h0);
        chk("t6_rst_ack", 32'(bus.req_ack_dm), 32'h0);
        chk("t6_rst_rd",  bus.rd_dm, 32'h0);
        resetn = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            int r, wt;
            r = $urandom_range(0, 4);
            case (r)
                0:       a = 32'(12'($urandom));
                1:       a = 32'h0001_0000 | 32'(12'($urandom));
                2:       a = 32'h0002_0000 | 32'(12'($urandom));
                3:       a = 32'h0000_1000 + 32'($urandom_range(0, 32'h0000_EFFF));
                default: a = $urandom;
            endcase
            wt = $urandom_range(0, 6);
            if (wt == 6) wt = NEVER;
            txn(a, 1'($urandom_range(0, 1)), $urandom, wt, $urandom, lat, rd, e);
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
